// File: rtl/bsg_test_node_client_multi.sv
// Multi-channel test-ring loopback client: per-channel FIFOs drained by a
// round-robin arbiter into one registered, client-id-tagged output stage.
//
// Ports:
//   clk_i, reset_n_i (async, active low)
//   en_i               node enable (gates accepts and grants)
//   v_i/data_i/ready_o input packet, valid-ready
//   v_o/data_o/yumi_i  output packet, valid-yumi
// Optional: BSG_TEST_NODE_CLIENT_SEQ_EN adds a 16-bit handshake sequence
// number at data_o[cell_width_p+sel_width +: 16].
module bsg_test_node_client_multi #(
  parameter int ring_width_p = 80,
  parameter int id_width_p   = 4,
  parameter int client_id_p  = 0,
  parameter int num_cells_p  = 4,
  parameter int cell_width_p = 10,
  parameter int fifo_els_p   = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i
);

  localparam int SEL_W = (num_cells_p > 1) ? $clog2(num_cells_p) : 1;
  localparam int AW    = $clog2(fifo_els_p);
  localparam int PW    = AW + 1;

  logic [cell_width_p-1:0] mem_q [num_cells_p][fifo_els_p];
  logic [PW-1:0]           wp_q  [num_cells_p];
  logic [PW-1:0]           rp_q  [num_cells_p];

  logic [num_cells_p-1:0]  empty, full, req;
  logic [SEL_W-1:0]        chan, gnt, ptr_q, ptr_d;
  logic [cell_width_p-1:0] payload;
  logic                    wr_ok, gnt_v, can_load;
  logic                    v_q, v_d;
  logic [ring_width_p-1:0] dat_q, dat_d;

  assign payload = data_i[cell_width_p-1:0];
  assign chan    = data_i[cell_width_p +: SEL_W];

  logic unused_hi;
  assign unused_hi = ^data_i[ring_width_p-1:cell_width_p+SEL_W];

  for (genvar c = 0; c < num_cells_p; c++) begin : g_st
    assign empty[c] = (wp_q[c] == rp_q[c]);
    assign full[c]  = ((wp_q[c] - rp_q[c]) == PW'(fifo_els_p));
  end

  // Full FIFO blocks input even if it is being read this cycle.
  assign ready_o = reset_n_i & en_i & ~|full;
  assign wr_ok   = v_i & ready_o & (32'(chan) < num_cells_p);
  assign req     = ~empty & {num_cells_p{en_i}};
  assign can_load = ~v_q | yumi_i;

  always_comb begin
    int t;
    logic [SEL_W-1:0] idx;
    logic found;
    t     = 0;
    idx   = '0;
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < num_cells_p; i++) begin
      t   = (int'(ptr_q) + i) % num_cells_p;
      idx = SEL_W'(t);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    gnt_v = found & can_load;
  end

  assign ptr_d = gnt_v ? SEL_W'((int'(gnt) + 1) % num_cells_p) : ptr_q;

  always_comb begin
    v_d   = v_q;
    dat_d = dat_q;
    if (v_q && yumi_i) v_d = 1'b0;
    if (gnt_v) begin
      v_d   = 1'b1;
      dat_d = '0;
      dat_d[ring_width_p-1 -: id_width_p] = id_width_p'(client_id_p);
      dat_d[cell_width_p +: SEL_W]        = gnt;
      dat_d[cell_width_p-1:0] = mem_q[gnt][rp_q[gnt][AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[chan][wp_q[chan][AW-1:0]] <= payload;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_cells_p; c++) begin
        wp_q[c] <= '0;
        rp_q[c] <= '0;
      end
      ptr_q <= '0;
      v_q   <= 1'b0;
      dat_q <= '0;
    end else begin
      for (int c = 0; c < num_cells_p; c++) begin
        if (wr_ok && chan == SEL_W'(c)) wp_q[c] <= wp_q[c] + PW'(1);
        if (gnt_v && gnt == SEL_W'(c))  rp_q[c] <= rp_q[c] + PW'(1);
      end
      ptr_q <= ptr_d;
      v_q   <= v_d;
      dat_q <= dat_d;
    end
  end

`ifdef BSG_TEST_NODE_CLIENT_SEQ_EN
  logic [15:0] seq_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)        seq_q <= '0;
    else if (v_q & yumi_i) seq_q <= seq_q + 16'd1;
  end
`endif

  // seq_q only moves on a handshake, so the held packet's field is stable.
  always_comb begin
    data_o = '0;
    if (v_q) begin
      data_o = dat_q;
`ifdef BSG_TEST_NODE_CLIENT_SEQ_EN
      data_o[cell_width_p+SEL_W +: 16] = seq_q;
`endif
    end
  end

  assign v_o = v_q;

endmodule

// File: tb/tb_bsg_test_node_client_multi.sv
// Bench for bsg_test_node_client_multi: queue-based reference model with a
// per-cycle compare, directed literal checks, then randomized traffic.
module tb_bsg_test_node_client_multi;

  localparam int RW  = 80;
  localparam int IW  = 4;
  localparam int CW  = 10;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int DEP = 2;
  localparam int CID = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, v = 1'b0, yumi = 1'b0;
  logic [RW-1:0] din = '0;
  logic ready, vo;
  logic [RW-1:0] dout;

  logic en3 = 1'b0, v3 = 1'b0, yumi3 = 1'b0;
  logic [RW-1:0] din3 = '0;
  logic ready3, vo3;
  logic [RW-1:0] dout3;

  always #5 clk = ~clk;

  bsg_test_node_client_multi #(
    .ring_width_p(RW), .id_width_p(IW), .client_id_p(CID),
    .num_cells_p(N), .cell_width_p(CW), .fifo_els_p(DEP)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .v_i(v),
    .data_i(din), .ready_o(ready), .v_o(vo), .data_o(dout),
    .yumi_i(yumi)
  );

  bsg_test_node_client_multi #(
    .ring_width_p(RW), .id_width_p(IW), .client_id_p(1),
    .num_cells_p(3), .cell_width_p(CW), .fifo_els_p(DEP)
  ) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en3), .v_i(v3),
    .data_i(din3), .ready_o(ready3), .v_o(vo3), .data_o(dout3),
    .yumi_i(yumi3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: one queue per channel plus the output slot.
  logic [CW-1:0] mq [N][$];
  bit            mov = 1'b0;
  logic [RW-1:0] mdat = '0;
  int            mptr = 0;
  logic [15:0]   mseq = '0;

  function automatic bit m_ready();
    bit r;
    r = rst_n && en;
    for (int c = 0; c < N; c++) if (mq[c].size() >= DEP) r = 1'b0;
    return r;
  endfunction

  function automatic logic [RW-1:0] m_data();
    logic [RW-1:0] r;
    r = '0;
    if (mov) begin
      r = mdat;
`ifdef BSG_TEST_NODE_CLIENT_SEQ_EN
      r[CW+SW +: 16] = mseq;
`endif
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    bit acc;
    int g, c2, ch;
    logic [CW-1:0] p;
    if (!rst_n) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      mov  = 1'b0;
      mdat = '0;
      mptr = 0;
      mseq = '0;
    end else begin
      acc = v && m_ready();
      g   = -1;
      if (en && (!mov || yumi))
        for (int i = 0; i < N; i++) begin
          c2 = (mptr + i) % N;
          if (g < 0 && mq[c2].size() > 0) g = c2;
        end
      if (mov && yumi) begin
        mov  = 1'b0;
        mseq = mseq + 16'd1;
      end
      if (g >= 0) begin
        p    = mq[g].pop_front();
        mdat = (RW'(CID) << (RW - IW)) | (RW'(g) << CW) | RW'(p);
        mov  = 1'b1;
        mptr = (g + 1) % N;
      end
      ch = int'(din[CW +: SW]);
      if (acc && ch < N) mq[ch].push_back(din[CW-1:0]);
    end
  end

  always @(negedge clk) begin
    #2;
    chk("ready_o", RW'(ready), RW'(m_ready()));
    chk("v_o", RW'(vo), RW'(mov));
    chk("data_o", dout, m_data());
  end

  always @(posedge clk)
    if (rst_n)
      assert (!(yumi && !vo)) else $error("illegal yumi_i while v_o low");

  function automatic logic [RW-1:0] pk(int ch, int p);
    logic [RW-1:0] r;
    r = '0;
    r[RW-1 -: IW] = IW'($urandom);
    r[CW +: SW]   = SW'(ch);
    r[CW-1:0]     = CW'(p);
    return r;
  endfunction

  task automatic step(bit vv, int ch, int p, bit ee, bit yy);
    @(negedge clk);
    v    = vv;
    din  = pk(ch, p);
    en   = ee;
    yumi = yy & mov & rst_n;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    v    = 1'b0;
    yumi = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_v_o", RW'(vo), '0);
    chk("rst_ready_o", RW'(ready), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step3(bit vv, int ch, int p, bit yy);
    @(negedge clk);
    v3    = vv;
    din3  = pk(ch, p);
    en3   = 1'b1;
    yumi3 = yy & vo3;
    #1;
  endtask

  logic [CW-1:0] got [$];

  initial begin
    repeat (3) @(negedge clk);
    chk("init_v_o", RW'(vo), '0);
    chk("init_ready_o", RW'(ready), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // single packet latency and layout
    step(1, 2, 'h155, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("lat_t1", RW'(vo), '0);
    step(0, 0, 0, 1, 0);
    chk("lat_t2", RW'(vo), RW'(1));
    chk("pkt_layout", dout, 80'h30000000000000000955);
    step(0, 0, 0, 1, 1);

    // fill channel 0 until backpressure
    step(1, 0, 1, 1, 0);
    step(1, 0, 2, 1, 0);
    step(1, 0, 3, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("full_ready", RW'(ready), '0);
    chk("full_head", RW'(dout[CW-1:0]), RW'(1));
    step(0, 0, 0, 1, 1);
    chk("yumi_ready_same", RW'(ready), '0);
    step(0, 0, 0, 1, 0);
    chk("yumi_ready_next", RW'(ready), RW'(1));
    chk("order_2", RW'(dout[CW-1:0]), RW'(2));
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("order_3", RW'(dout[CW-1:0]), RW'(3));
    step(0, 0, 0, 1, 1);

    // round robin over all channels, back-to-back
    do_reset();
    for (int c = 0; c < N; c++) step(1, c, 'h10 + c, 1, 0);
    got.delete();
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, 1, 1);
      if (yumi) got.push_back(dout[CW-1:0]);
    end
    chk("rr_count", RW'(got.size()), RW'(N));
    for (int i = 0; i < got.size(); i++)
      chk("rr_order", RW'(got[i]), RW'('h10 + i));
    step(0, 0, 0, 1, 0);

    // enable drop: held packet drains, nothing new
    step(1, 1, 'h2A, 1, 0);
    step(1, 2, 'h2B, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 3, 'h3C, 0, 1);
    chk("en0_v_o", RW'(vo), '0);
    chk("en0_ready", RW'(ready), '0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("en1_v_o", RW'(vo), RW'(1));
    chk("en1_pay", RW'(dout[CW-1:0]), RW'('h2B));
    step(0, 0, 0, 1, 1);

    // reset in the middle of a burst
    for (int c = 0; c < N; c++) step(1, c, 'h50 + c, 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("post_rst_v_o", RW'(vo), '0);
    step(1, 0, 'h77, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("post_rst_pay", RW'(dout[CW-1:0]), RW'('h77));
    chk("post_rst_seq", RW'(dout[CW+SW +: 16]), '0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);

    // three-channel instance: out-of-range channel discarded
    for (int i = 0; i < 4; i++) begin
      step3(1, 3, 'hAA, 0);
      chk("oor_ready", RW'(ready3), RW'(1));
    end
    for (int i = 0; i < 4; i++) step3(0, 0, 0, 0);
    chk("oor_no_out", RW'(vo3), '0);
    step3(1, 2, 'hBB, 0);
    step3(0, 0, 0, 0);
    step3(0, 0, 0, 0);
    chk("n3_v_o", RW'(vo3), RW'(1));
    chk("n3_pkt", dout3, 80'h100000000000000008BB);
    step3(0, 0, 0, 1);
    step3(0, 0, 0, 0);
    chk("n3_drained", RW'(vo3), '0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 799) != 0);
      v     = ($urandom_range(0, 9) < 7);
      din   = pk($urandom_range(0, N - 1), $urandom);
      en    = ($urandom_range(0, 9) != 0);
      yumi  = mov & rst_n & ($urandom_range(0, 9) < 6);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
